// File: rtl/sd_rx_burst_filler_pkg.sv
// Shared Wishbone cycle-type encodings and FSM state type for the SD receive burst filler.
package sd_rx_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        BURST,
        ERR
    } state_t;

endpackage

// File: rtl/sd_rx_burst_filler_if.sv
// Wishbone B3 master bus bundle between the burst filler and the system arbiter.
interface sd_rx_burst_filler_if #(
    parameter int unsigned DW = 32
) ();
    localparam int unsigned SEL_W = DW / 8;

    logic [31:0]      m_wb_adr_o;
    logic [DW-1:0]    m_wb_dat_o;
    logic [SEL_W-1:0] m_wb_sel_o;
    logic             m_wb_we_o;
    logic             m_wb_cyc_o;
    logic             m_wb_stb_o;
    logic [2:0]       m_wb_cti_o;
    logic [1:0]       m_wb_bte_o;
    logic             m_wb_ack_i;
    logic             m_wb_err_i;

    modport master (
        output m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o,
               m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
        input  m_wb_ack_i, m_wb_err_i
    );

    modport slave (
        input  m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o,
               m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
        output m_wb_ack_i, m_wb_err_i
    );
endinterface

// File: rtl/sd_rx_burst_filler_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush; head word is visible one edge after its push.
module sd_rx_sync_fifo #(
    parameter int unsigned DW         = 32,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DW-1:0]         din,
    input  logic                  pop,
    output logic [DW-1:0]         dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int unsigned        CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]      DEPTH = CW'(1 << DEPTH_LOG2);
    localparam logic [CW-1:0]      ONE   = CW'(1);

    logic [DW-1:0] mem [1 << DEPTH_LOG2];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is kept when paired with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == DEPTH);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE;
            if (do_pop)  rd_ptr <= rd_ptr + ONE;
        end
    end
endmodule

// File: rtl/sd_rx_burst_filler.sv
// SD receive FIFO drained to memory as a Wishbone B3 master, using incrementing bursts when enough words are queued.
module sd_rx_burst_filler
    import sd_rx_pkg::*;
#(
    parameter int unsigned DW         = 32,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned OFFSET_W   = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [31:0]           adr,
    input  logic                  wr,
    input  logic [DW-1:0]         dat_i,
    sd_rx_burst_filler_if.master  wb,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  bus_err
);
    localparam int unsigned       CW        = DEPTH_LOG2 + 1;
    localparam int unsigned       SHIFT     = $clog2(DW / 8);
    localparam logic [CW-1:0]     BURST_CNT = CW'(BURST_LEN);
    localparam logic [CW-1:0]     LAST_BEAT = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0]     PENULT    = CW'(BURST_LEN - 2);
    localparam logic [CW-1:0]     BEAT_ONE  = CW'(1);
    localparam logic [OFFSET_W-1:0] OFS_ONE = OFFSET_W'(1);

    state_t                state;
    logic [CW-1:0]         count;
    logic [CW-1:0]         beat;
    logic [OFFSET_W-1:0]   offset;
    logic                  cyc_q;
    logic                  stb_q;
    logic [2:0]            cti_q;
    logic                  overflow_q;
    logic                  bus_err_q;
    logic                  beat_ack;
    logic [DW-1:0]         fifo_dout;

    // err outranks ack; an errored beat never pops the FIFO.
    assign beat_ack = ((state == SINGLE) || (state == BURST)) && wb.m_wb_ack_i && !wb.m_wb_err_i;

    sd_rx_sync_fifo #(
        .DW         (DW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (!en),
        .push  (wr && en),
        .din   (dat_i),
        .pop   (beat_ack),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat       <= '0;
            offset     <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            cti_q      <= CTI_CLASSIC;
            overflow_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else if (!en) begin
            state      <= IDLE;
            beat       <= '0;
            offset     <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            cti_q      <= CTI_CLASSIC;
            overflow_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            if (wr && full && !beat_ack)
                overflow_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (count >= BURST_CNT) begin
                        state <= BURST;
                        cyc_q <= 1'b1;
                        stb_q <= 1'b1;
                        cti_q <= (BURST_LEN == 1) ? CTI_EOB : CTI_INCR;
                        beat  <= '0;
                    end else if (count != '0) begin
                        state <= SINGLE;
                        cyc_q <= 1'b1;
                        stb_q <= 1'b1;
                        cti_q <= CTI_CLASSIC;
                    end
                end
                SINGLE, BURST: begin
                    if (wb.m_wb_err_i) begin
                        state     <= ERR;
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        bus_err_q <= 1'b1;
                    end else if (wb.m_wb_ack_i) begin
                        offset <= offset + OFS_ONE;
                        beat   <= beat + BEAT_ONE;
                        if (state == SINGLE || beat == LAST_BEAT) begin
                            state <= IDLE;
                            cyc_q <= 1'b0;
                            stb_q <= 1'b0;
                            cti_q <= CTI_CLASSIC;
                        end else if (beat == PENULT) begin
                            cti_q <= CTI_EOB;
                        end
                    end
                end
                ERR: ;
                default: state <= IDLE;
            endcase
        end
    end

    assign wb.m_wb_adr_o = adr + (32'(offset) << SHIFT);
    assign wb.m_wb_dat_o = fifo_dout;
    assign wb.m_wb_sel_o = '1;
    assign wb.m_wb_we_o  = cyc_q;
    assign wb.m_wb_cyc_o = cyc_q;
    assign wb.m_wb_stb_o = stb_q;
    assign wb.m_wb_cti_o = cti_q;
    assign wb.m_wb_bte_o = BTE_LINEAR;
    assign overflow      = overflow_q;
    assign bus_err       = bus_err_q;
endmodule
